// File: rtl/dual_port_ram_v2.sv
// Parametrised true dual-port synchronous RAM with post-reset zeroing sweep,
// selectable read-during-write mode and same-address collision reporting.
// Optional macro DPRAM_OUT_REG_EN adds a second output register stage.
module dual_port_ram_v2 #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int RD_MODE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b,
  output logic              vld_a,
  output logic              vld_b,
  output logic              busy,
  output logic              coll,
  output logic [15:0]       coll_cnt,
  output logic              state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              ready;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_a, acc_b, wr_a, wr_b, b_drop;
  logic [DATA_W-1:0] dq_a, dq_b;
  logic              vq_a, vq_b;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Next-state logic: leave INIT once the last address has been zeroed
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (ptr == {ADDR_W{1'b1}}) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state == ST_INIT);
    ready     = (state == ST_READY);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (rst)       ptr <= '0;
    else if (busy) ptr <= ptr + 1'b1;
  end

  // Handshake: en_x is a request that is always accepted while ready (no
  // backpressure); vld_x is a one-cycle valid marking a fresh dout_x.
  assign acc_a  = ready & en_a;
  assign acc_b  = ready & en_b;
  assign wr_a   = acc_a & we_a;
  assign wr_b   = acc_b & we_b;
  assign b_drop = wr_a & wr_b & (addr_a == addr_b);

  // Port A wins a same-address write; port B's write is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[ptr] <= '0;
      end else begin
        if (wr_a)           mem[addr_a] <= din_a;
        if (wr_b && !b_drop) mem[addr_b] <= din_b;
      end
    end
  end

  // Reads sample the pre-edge array, so cross-port readers see old data
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_a <= '0;
      vq_a <= 1'b0;
    end else begin
      vq_a <= 1'b0;
      if (acc_a && (!we_a || RD_MODE != 2)) begin
        vq_a <= 1'b1;
        dq_a <= (we_a && RD_MODE == 1) ? din_a : mem[addr_a];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dq_b <= '0;
      vq_b <= 1'b0;
    end else begin
      vq_b <= 1'b0;
      if (acc_b && (!we_b || RD_MODE != 2)) begin
        vq_b <= 1'b1;
        dq_b <= (we_b && RD_MODE == 1) ? din_b : mem[addr_b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll     <= 1'b0;
      coll_cnt <= '0;
    end else begin
      coll <= b_drop;
      if (b_drop && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic [DATA_W-1:0] dr_a, dr_b;
  logic              vr_a, vr_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      dr_a <= '0;
      dr_b <= '0;
      vr_a <= 1'b0;
      vr_b <= 1'b0;
    end else begin
      dr_a <= dq_a;
      dr_b <= dq_b;
      vr_a <= vq_a;
      vr_b <= vq_b;
    end
  end

  assign dout_a = dr_a;
  assign dout_b = dr_b;
  assign vld_a  = vr_a;
  assign vld_b  = vr_b;
`else
  assign dout_a = dq_a;
  assign dout_b = dq_b;
  assign vld_a  = vq_a;
  assign vld_b  = vq_b;
`endif

endmodule

// File: tb/tb_dual_port_ram_v2.sv
// Bench for dual_port_ram_v2: three instances (RD_MODE 0/1/2) share one
// stimulus stream; expected read returns are queued and checked by a monitor.
module tb_dual_port_ram_v2;

`ifdef DPRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, we_a, en_b, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] din_a, din_b;

  logic [7:0]  dout_a_m [3];
  logic [7:0]  dout_b_m [3];
  logic        vld_a_m  [3];
  logic        vld_b_m  [3];
  logic        busy_m   [3];
  logic        coll_m   [3];
  logic [15:0] cnt_m    [3];
  logic        state_m  [3];

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          busy_left = 0;
  logic        mon_en = 1'b0;
  logic        chk_coll = 1'b1;
  logic        exp_coll = 1'b0;
  logic [15:0] mdl_cnt = '0;
  logic [7:0]  ref_mem [64];
  logic [7:0]  last [6];
  logic [7:0]  exp_q [6][$];
  int          exp_t [6][$];

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dual_port_ram_v2 #(.DATA_W(8), .ADDR_W(6), .RD_MODE(0)) u_m0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_a(dout_a_m[0]), .dout_b(dout_b_m[0]), .vld_a(vld_a_m[0]), .vld_b(vld_b_m[0]),
    .busy(busy_m[0]), .coll(coll_m[0]), .coll_cnt(cnt_m[0]), .state_dbg(state_m[0])
  );

  dual_port_ram_v2 #(.DATA_W(8), .ADDR_W(6), .RD_MODE(1)) u_m1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_a(dout_a_m[1]), .dout_b(dout_b_m[1]), .vld_a(vld_a_m[1]), .vld_b(vld_b_m[1]),
    .busy(busy_m[1]), .coll(coll_m[1]), .coll_cnt(cnt_m[1]), .state_dbg(state_m[1])
  );

  dual_port_ram_v2 #(.DATA_W(8), .ADDR_W(6), .RD_MODE(2)) u_m2 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_a(dout_a_m[2]), .dout_b(dout_b_m[2]), .vld_a(vld_a_m[2]), .vld_b(vld_b_m[2]),
    .busy(busy_m[2]), .coll(coll_m[2]), .coll_cnt(cnt_m[2]), .state_dbg(state_m[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int qi, input logic [7:0] v);
    exp_q[qi].push_back(v);
    exp_t[qi].push_back(cyc + LAT);
  endtask

  // Driver: one clock cycle of stimulus, model update and status checks
  task automatic step(input logic ea, input logic wa, input logic [5:0] aa, input logic [7:0] da,
                      input logic eb, input logic wb, input logic [5:0] ab, input logic [7:0] db);
    logic       nc;
    logic [7:0] oa, ob;
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("busy_m%0d", m), 32'(busy_m[m]), 32'(busy_left > 0));
      if (chk_coll) begin
        chk($sformatf("coll_m%0d", m), 32'(coll_m[m]), 32'(exp_coll));
        chk($sformatf("coll_cnt_m%0d", m), 32'(cnt_m[m]), 32'(mdl_cnt));
      end
    end
    nc = 1'b0;
    if (busy_left == 0) begin
      oa = ref_mem[aa];
      ob = ref_mem[ab];
      for (int m = 0; m < 3; m++) begin
        if (ea && (!wa || m != 2)) push(m * 2,     (wa && m == 1) ? da : oa);
        if (eb && (!wb || m != 2)) push(m * 2 + 1, (wb && m == 1) ? db : ob);
      end
      if (eb && wb) ref_mem[ab] = db;
      if (ea && wa) ref_mem[aa] = da;
      nc = ea && wa && eb && wb && (aa == ab);
    end
    @(negedge clk);
    if (busy_left > 0) busy_left--;
    exp_coll = nc;
    if (nc && mdl_cnt != 16'hFFFF) mdl_cnt++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 6'd0, 8'd0, 0, 0, 6'd0, 8'd0);
  endtask

  task automatic do_reset(input logic req);
    mon_en = 1'b0;
    rst = 1'b1;
    en_a = req; we_a = req; addr_a = 6'd0; din_a = 8'hFF;
    en_b = req; we_b = 1'b0; addr_b = 6'd1; din_b = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
    busy_left = 64;
    exp_coll = 1'b0;
    mdl_cnt = '0;
    for (int k = 0; k < 64; k++) ref_mem[k] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      last[k] = 8'h00;
      exp_q[k].delete();
      exp_t[k].delete();
    end
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst_busy_m%0d", m),   32'(busy_m[m]),   32'd1);
      chk($sformatf("rst_dout_a_m%0d", m), 32'(dout_a_m[m]), 32'd0);
      chk($sformatf("rst_dout_b_m%0d", m), 32'(dout_b_m[m]), 32'd0);
      chk($sformatf("rst_vld_a_m%0d", m),  32'(vld_a_m[m]),  32'd0);
      chk($sformatf("rst_vld_b_m%0d", m),  32'(vld_b_m[m]),  32'd0);
      chk($sformatf("rst_coll_m%0d", m),   32'(coll_m[m]),   32'd0);
      chk($sformatf("rst_cnt_m%0d", m),    32'(cnt_m[m]),    32'd0);
    end
    mon_en = 1'b1;
  endtask

  // Scoreboard monitor: pops an expectation whenever an instance raises vld
  always @(negedge clk) begin : monitor
    logic       v;
    logic [7:0] d, ed;
    int         qi, et;
    if (mon_en) begin
      for (int m = 0; m < 3; m++) begin
        for (int p = 0; p < 2; p++) begin
          qi = m * 2 + p;
          v  = (p == 0) ? vld_a_m[m]  : vld_b_m[m];
          d  = (p == 0) ? dout_a_m[m] : dout_b_m[m];
          n_chk++;
          if (v) begin
            if (exp_q[qi].size() == 0) begin
              n_fail++;
              $display("FAIL vld_m%0d_p%0d: unexpected vld with dout %0h, required no vld (cycle %0d)", m, p, d, cyc);
              last[qi] = d;
            end else begin
              ed = exp_q[qi].pop_front();
              et = exp_t[qi].pop_front();
              if (d !== ed || et != cyc) begin
                n_fail++;
                $display("FAIL dout_m%0d_p%0d: got %0h at cycle %0d, required %0h at cycle %0d", m, p, d, cyc, ed, et);
              end
              last[qi] = ed;
            end
          end else if (exp_t[qi].size() > 0 && exp_t[qi][0] <= cyc) begin
            n_fail++;
            ed = exp_q[qi].pop_front();
            et = exp_t[qi].pop_front();
            $display("FAIL vld_m%0d_p%0d: no vld, required dout %0h at cycle %0d", m, p, ed, et);
          end else if (d !== last[qi]) begin
            n_fail++;
            $display("FAIL hold_m%0d_p%0d: dout %0h changed without vld, required %0h (cycle %0d)", m, p, d, last[qi], cyc);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b0;
    en_a = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0;
    en_b = 1'b0; we_b = 1'b0; addr_b = '0; din_b = '0;
    @(negedge clk);

    // Reset, full sweep, then every address reads back zero
    do_reset(1'b0);
    idle(64);
    for (int i = 0; i < 64; i++) step(1, 0, 6'(i), 8'h00, 1, 0, 6'(63 - i), 8'h00);

    // Write on A, read on B the following cycle
    step(1, 1, 6'd5, 8'hA5, 0, 0, 6'd0, 8'h00);
    step(0, 0, 6'd0, 8'h00, 1, 0, 6'd5, 8'h00);

    // Same-address double write: A wins, collision reported
    step(1, 1, 6'd9, 8'h11, 1, 1, 6'd9, 8'h22);
    step(1, 0, 6'd9, 8'h00, 1, 0, 6'd9, 8'h00);

    // Cross-port write/read on one address returns old data
    step(1, 1, 6'd7, 8'h3C, 1, 0, 6'd7, 8'h00);
    step(1, 0, 6'd7, 8'h00, 1, 0, 6'd7, 8'h00);

    // Read-during-write on port A in each RD_MODE
    step(1, 1, 6'd2, 8'h10, 0, 0, 6'd0, 8'h00);
    step(1, 1, 6'd2, 8'h20, 0, 0, 6'd0, 8'h00);
    step(1, 0, 6'd2, 8'h00, 0, 0, 6'd0, 8'h00);

    // Independent writes on different addresses, then cross reads
    step(1, 1, 6'd20, 8'h5A, 1, 1, 6'd21, 8'hC3);
    step(1, 0, 6'd21, 8'h00, 1, 0, 6'd20, 8'h00);
    step(1, 0, 6'd20, 8'h00, 1, 0, 6'd20, 8'h00);
    step(0, 0, 6'd0, 8'h00, 1, 1, 6'd63, 8'h77);
    step(1, 0, 6'd63, 8'h00, 0, 0, 6'd0, 8'h00);
    idle(3);

    // Saturate the collision counter
    chk_coll = 1'b0;
    for (int i = 0; i < 65536; i++) step(1, 1, 6'd10, 8'(i), 1, 1, 6'd10, ~8'(i));
    chk_coll = 1'b1;
    for (int m = 0; m < 3; m++) chk($sformatf("sat_cnt_m%0d", m), 32'(cnt_m[m]), 32'h0000FFFF);
    step(1, 0, 6'd10, 8'h00, 1, 1, 6'd10, 8'h00);
    step(1, 1, 6'd10, 8'h01, 1, 1, 6'd10, 8'h02);
    step(1, 0, 6'd10, 8'h00, 0, 0, 6'd0, 8'h00);
    idle(3);

    // Reset mid-sweep with requests pending; sweep restarts from zero
    do_reset(1'b0);
    idle(30);
    do_reset(1'b1);
    idle(62);
    step(1, 1, 6'd3, 8'hEE, 1, 1, 6'd4, 8'hDD);
    idle(1);
    for (int i = 0; i < 64; i++) step(1, 0, 6'(i), 8'h00, 1, 0, 6'(i), 8'h00);
    idle(4);

    for (int k = 0; k < 6; k++) chk($sformatf("drain_q%0d", k), 32'(exp_q[k].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
